uart_vram_loader: RTL and testbench
===================================

UART_VRAM_LOADER -- requirements
Module: uart_vram_loader

Interface
REQ-001 The block SHALL have parameter BYTES_PER_WORD, default 2, meaning the number of received bytes packed into one word (legal values 1..4).
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning the write-address width.
REQ-003 The block SHALL have parameter WRAP_MODE, default 1, meaning: 1 = address wraps at end; 0 = address stops at end and further words are dropped.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the number of idle clocks after which a partial word is discarded.
REQ-005 The block SHALL have one clock, CLK (input, 1 bit); reset is asynchronous and active-low, RST_N (input, 1 bit).
REQ-006 RX_DATA  input  8  received UART byte.
REQ-007 RX_VALID  input  1  one-cycle strobe; RX_DATA is valid this cycle.
REQ-008 ADDR_LOAD  input  1  one-cycle strobe to load the next write address.
REQ-009 ADDR_IN  input  ADDR_W  address value loaded by ADDR_LOAD.
REQ-010 WR_EN  output  1  one-cycle VRAM write strobe.
REQ-011 WR_ADDR  output  ADDR_W  VRAM write address, valid while WR_EN=1.
REQ-012 WR_DATA  output  8*BYTES_PER_WORD  assembled word; holds the last written word between writes (debug/7-seg display).
REQ-013 FULL  output  1  WRAP_MODE=0 only: the last address has been written.
REQ-014 DROPPED  output  1  sticky: a partial word was discarded by timeout or a word was dropped while FULL.

Function
REQ-015 FSM states: COLLECT (byte count 0..BYTES_PER_WORD-1) and WRITE (one cycle).
REQ-016 Byte packing is big-endian: the first byte of a word goes to the MSBs and the last byte to bits [7:0].
REQ-017 A RX_VALID with byte count BYTES_PER_WORD-1 moves the FSM to WRITE; WR_EN=1 for exactly one cycle on the next clock edge (latency 1 clock after the last byte).
REQ-018 In WRITE, WR_ADDR equals the pointer; the pointer increments by 1 after the write.
REQ-019 Wrap: WRAP_MODE=1 makes the pointer go 2^ADDR_W-1 -> 0.
REQ-020 Stop: WRAP_MODE=0 holds the pointer at 2^ADDR_W-1 after that write and sets FULL; later complete words produce no WR_EN and set DROPPED.
REQ-021 With BYTES_PER_WORD=1, every RX_VALID produces a write.
REQ-022 The idle counter resets on every RX_VALID and counts only while the byte count is nonzero.
REQ-023 When the idle counter reaches TIMEOUT_CYCLES, the byte count returns to 0, the partial bytes are discarded, DROPPED=1, and there is no write.
REQ-024 ADDR_LOAD sets the pointer to ADDR_IN, clears FULL and the byte count, and has no effect on DROPPED.
REQ-025 ADDR_LOAD in the same cycle as a WRITE: the write uses the old pointer; the pointer then becomes ADDR_IN (not ADDR_IN+1).
REQ-026 ADDR_LOAD in the same cycle as RX_VALID: the load takes effect and that byte becomes byte 0 of a new word.
REQ-027 RX_VALID during the WRITE cycle SHALL be accepted as byte 0 of the next word (no byte loss at back-to-back bytes).

Reset
REQ-028 RST_N=0 SHALL asynchronously clear: pointer=0, byte count=0, state=COLLECT, WR_EN=0, WR_DATA=0, FULL=0, DROPPED=0, idle counter=0.
REQ-029 Reset mid-word SHALL discard the partial bytes; the first word after release is written to address 0.
REQ-030 Release of RST_N SHALL be synchronised externally; the block needs no internal reset synchroniser.

Structure
REQ-031 Package uart_vram_pkg SHALL hold the BYTE_W=8 constant, the FSM state typedef and the wrap/stop mode constants.
REQ-032 The idle timer SHALL be sub-module rx_idle_timer (parameter TIMEOUT_CYCLES; inputs CLK, RST_N, clear, run; output expired pulse).
REQ-033 The 7-segment display SHALL connect to WR_DATA[15:0].

Verification
REQ-034 Defaults; bytes 0x12,0x34,0x56,0x78 -> WR_EN at addr 0 data 0x1234, then addr 1 data 0x5678, each 1 clock after the 2nd byte.
REQ-035 ADDR_W=2, WRAP_MODE=0; 5 words -> writes at 0..3, FULL=1 after the 4th, 5th word has no WR_EN and DROPPED=1; ADDR_LOAD 0 -> FULL=0.
REQ-036 TIMEOUT_CYCLES=100; byte 0xAA, wait 100 clocks, bytes 0x01,0x02 -> DROPPED=1, single write data 0x0102 at addr 0.
REQ-037 ADDR_LOAD ADDR_IN=0x200 coincident with the WRITE of word at addr 5 -> write addr 5; next word at 0x200.
REQ-038 BYTES_PER_WORD=3, RX_VALID every clock for 6 bytes 0x01..0x06 -> writes 0x010203 at addr 0 and 0x040506 at addr 1, no byte lost.
REQ-039 Assert RST_N=0 after one byte of a word, release, send 0xBE,0xEF -> outputs 0 during reset; write 0xBEEF at addr 0.

Source files
------------

// File: rtl/uart_vram_pkg.sv
// Shared constants and types for the UART-to-VRAM loader.
package uart_vram_pkg;

   localparam int BYTE_W    = 8;
   localparam int MODE_STOP = 0;   // pointer parks on the last address, later words dropped
   localparam int MODE_WRAP = 1;   // pointer rolls over to address 0

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_WRITE   = 1'b1
   } state_e;

endpackage

// File: rtl/uart_vram_loader_if.sv
// Byte-in / VRAM-write-out bundle of the loader. The byte source and the
// VRAM master side use the master modport; the loader itself uses slave.
interface uart_vram_loader_if
   import uart_vram_pkg::*;
#(
   parameter int ADDR_W         = 10,
   parameter int BYTES_PER_WORD = 2
);

   logic [BYTE_W-1:0]                RX_DATA;
   logic                             RX_VALID;
   logic                             ADDR_LOAD;
   logic [ADDR_W-1:0]                ADDR_IN;
   logic                             WR_EN;
   logic [ADDR_W-1:0]                WR_ADDR;
   logic [BYTE_W*BYTES_PER_WORD-1:0] WR_DATA;
   logic                             FULL;
   logic                             DROPPED;

   modport master (
      output RX_DATA, RX_VALID, ADDR_LOAD, ADDR_IN,
      input  WR_EN, WR_ADDR, WR_DATA, FULL, DROPPED
   );

   modport slave (
      input  RX_DATA, RX_VALID, ADDR_LOAD, ADDR_IN,
      output WR_EN, WR_ADDR, WR_DATA, FULL, DROPPED
   );

endinterface

// File: rtl/rx_idle_timer.sv
// Counts idle clocks while a partial word is pending and flags expiry.
// expired is high during the TIMEOUT_CYCLES-th idle clock, so the owner
// discards the partial word on the edge that completes that idle period.
module rx_idle_timer #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;

   assign expired = run && !clear && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Idle counter: restarts on activity, on expiry and whenever nothing is pending.
   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else if (clear || expired || !run) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_vram_loader.sv
// Packs received UART bytes big-endian into words and writes them to VRAM
// at an auto-incrementing pointer. WR_DATA[15:0] drives the 7-seg display.
module uart_vram_loader
   import uart_vram_pkg::*;
#(
   parameter int BYTES_PER_WORD = 2,
   parameter int ADDR_W         = 10,
   parameter int WRAP_MODE      = MODE_WRAP,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic               CLK,
   input  logic               RST_N,
   uart_vram_loader_if.slave  bus
);

   localparam int                WORD_W    = BYTE_W * BYTES_PER_WORD;
   localparam int                CNT_W     = $clog2(BYTES_PER_WORD + 1);
   localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

   state_e              state_q;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic                full_q, full_d;
   logic [CNT_W-1:0]    cnt_q, cnt_base;
   logic [WORD_W-1:0]   shift_q, word_d;
   logic                wr_en_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [WORD_W-1:0]   wr_data_q;
   logic                dropped_q;
   logic                expired;
   logic                word_done;
   logic                drop_word;

   rx_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .clear   (bus.RX_VALID || bus.ADDR_LOAD),
      .run     (cnt_q != '0),
      .expired (expired)
   );

   // Pointer/full after this edge and whether the incoming byte closes a word.
   // A write leaves WRITE with pointer+1 unless ADDR_LOAD overrides it; the
   // resulting pointer is also the address of a word completing this cycle.
   // Old bytes need no clearing: exactly BYTES_PER_WORD shifts push them out.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cnt_base  = (bus.ADDR_LOAD || expired) ? '0 : cnt_q;
      word_d    = (shift_q << BYTE_W) | WORD_W'(bus.RX_DATA);
      word_done = bus.RX_VALID && (cnt_base == LAST_BYTE);
      ptr_d     = ptr_q;
      full_d    = full_q;
      if (bus.ADDR_LOAD) begin
         ptr_d  = bus.ADDR_IN;
         full_d = 1'b0;
      end else if (state_q == ST_WRITE) begin
         if (WRAP_MODE == MODE_WRAP || ptr_q != ADDR_MAX) begin
            ptr_d = ptr_q + 1'b1;
         end else begin
            full_d = 1'b1;
         end
      end
      drop_word = word_done && full_d;
   end

   // COLLECT/WRITE FSM with registered write strobe, address and data.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_COLLECT;
         ptr_q     <= '0;
         full_q    <= 1'b0;
         cnt_q     <= '0;
         shift_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         dropped_q <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         full_q    <= full_d;
         dropped_q <= dropped_q || expired || drop_word;
         if (bus.RX_VALID) begin
            shift_q <= word_d;
            cnt_q   <= word_done ? '0 : cnt_base + 1'b1;
         end else begin
            cnt_q   <= cnt_base;
         end
         state_q <= ST_COLLECT;
         wr_en_q <= 1'b0;
         if (word_done && !full_d) begin
            state_q   <= ST_WRITE;
            wr_en_q   <= 1'b1;
            wr_addr_q <= ptr_d;
            wr_data_q <= word_d;
         end
      end
   end

   assign bus.WR_EN   = wr_en_q;
   assign bus.WR_ADDR = wr_addr_q;
   assign bus.WR_DATA = wr_data_q;
   assign bus.FULL    = full_q;
   assign bus.DROPPED = dropped_q;

endmodule

// File: tb/tb_uart_vram_loader.sv
// Directed bench for uart_vram_loader over four parameter sets. Expected
// writes are queued as bytes are driven and popped by a write monitor.
module tb_uart_vram_loader;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
      time         t;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [7:0] rx_data [4];
   logic [3:0] rx_valid;
   logic [3:0] addr_load;
   logic [9:0] addr_in [4];

   logic [3:0]  mon_en;
   logic [9:0]  mon_addr [4];
   logic [31:0] mon_data [4];

   exp_t sb0[$], sb1[$], sb2[$], sb3[$];
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   // 0: defaults (short timeout)  1: 4-deep stop mode  2: 3-byte words  3: 1-byte words, 8-deep
   uart_vram_loader_if #(.ADDR_W(10), .BYTES_PER_WORD(2)) if_def ();
   uart_vram_loader_if #(.ADDR_W(2),  .BYTES_PER_WORD(2)) if_stop ();
   uart_vram_loader_if #(.ADDR_W(10), .BYTES_PER_WORD(3)) if_b3 ();
   uart_vram_loader_if #(.ADDR_W(3),  .BYTES_PER_WORD(1)) if_b1 ();

   uart_vram_loader #(.BYTES_PER_WORD(2), .ADDR_W(10), .WRAP_MODE(1), .TIMEOUT_CYCLES(100))
      u_def  (.CLK(CLK), .RST_N(RST_N), .bus(if_def.slave));
   uart_vram_loader #(.BYTES_PER_WORD(2), .ADDR_W(2), .WRAP_MODE(0), .TIMEOUT_CYCLES(100))
      u_stop (.CLK(CLK), .RST_N(RST_N), .bus(if_stop.slave));
   uart_vram_loader #(.BYTES_PER_WORD(3), .ADDR_W(10), .WRAP_MODE(1), .TIMEOUT_CYCLES(100))
      u_b3   (.CLK(CLK), .RST_N(RST_N), .bus(if_b3.slave));
   uart_vram_loader #(.BYTES_PER_WORD(1), .ADDR_W(3), .WRAP_MODE(1), .TIMEOUT_CYCLES(100))
      u_b1   (.CLK(CLK), .RST_N(RST_N), .bus(if_b1.slave));

   assign if_def.RX_DATA    = rx_data[0];
   assign if_def.RX_VALID   = rx_valid[0];
   assign if_def.ADDR_LOAD  = addr_load[0];
   assign if_def.ADDR_IN    = addr_in[0];
   assign if_stop.RX_DATA   = rx_data[1];
   assign if_stop.RX_VALID  = rx_valid[1];
   assign if_stop.ADDR_LOAD = addr_load[1];
   assign if_stop.ADDR_IN   = addr_in[1][1:0];
   assign if_b3.RX_DATA     = rx_data[2];
   assign if_b3.RX_VALID    = rx_valid[2];
   assign if_b3.ADDR_LOAD   = addr_load[2];
   assign if_b3.ADDR_IN     = addr_in[2];
   assign if_b1.RX_DATA     = rx_data[3];
   assign if_b1.RX_VALID    = rx_valid[3];
   assign if_b1.ADDR_LOAD   = addr_load[3];
   assign if_b1.ADDR_IN     = addr_in[3][2:0];

   assign mon_en      = {if_b1.WR_EN, if_b3.WR_EN, if_stop.WR_EN, if_def.WR_EN};
   assign mon_addr[0] = if_def.WR_ADDR;
   assign mon_addr[1] = 10'(if_stop.WR_ADDR);
   assign mon_addr[2] = if_b3.WR_ADDR;
   assign mon_addr[3] = 10'(if_b1.WR_ADDR);
   assign mon_data[0] = 32'(if_def.WR_DATA);
   assign mon_data[1] = 32'(if_stop.WR_DATA);
   assign mon_data[2] = 32'(if_b3.WR_DATA);
   assign mon_data[3] = 32'(if_b1.WR_DATA);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pending();
      return sb0.size() + sb1.size() + sb2.size() + sb3.size();
   endfunction

   task automatic push(input int id, input logic [9:0] a, input logic [31:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.t    = $time + 5;   // strobe must be visible at the negedge right after the last byte's edge
      case (id)
         0:       sb0.push_back(e);
         1:       sb1.push_back(e);
         2:       sb2.push_back(e);
         default: sb3.push_back(e);
      endcase
   endtask

   // Every WR_EN seen mid-cycle must match the head of that instance's queue.
   always @(negedge CLK) begin : write_monitor
      exp_t e;
      bit   have;
      if (RST_N === 1'b1) begin
         for (int i = 0; i < 4; i++) begin
            if (mon_en[i] === 1'b1) begin
               have = 1'b0;
               case (i)
                  0:       if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
                  1:       if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
                  2:       if (sb2.size() > 0) begin e = sb2.pop_front(); have = 1'b1; end
                  default: if (sb3.size() > 0) begin e = sb3.pop_front(); have = 1'b1; end
               endcase
               if (!have) begin
                  check($sformatf("unexpected_write_dut%0d", i), 32'(mon_en[i]), 32'd0);
               end else begin
                  check($sformatf("wr_addr_dut%0d", i), 32'(mon_addr[i]), 32'(e.addr));
                  check($sformatf("wr_data_dut%0d", i), mon_data[i], e.data);
                  check($sformatf("wr_latency_dut%0d", i), 32'($time), 32'(e.t));
               end
            end
         end
      end
   end

   // One byte, sampled on the next rising edge.
   task automatic send_byte(input int id, input logic [7:0] b);
      rx_data[id]  = b;
      rx_valid[id] = 1'b1;
      @(posedge CLK);
      #1 rx_valid[id] = 1'b0;
   endtask

   // Last byte of a word: the write it triggers is queued on the sampling edge.
   task automatic send_last(input int id, input logic [7:0] b, input logic [9:0] a, input logic [31:0] d);
      rx_data[id]  = b;
      rx_valid[id] = 1'b1;
      @(posedge CLK);
      push(id, a, d);
      #1 rx_valid[id] = 1'b0;
   endtask

   task automatic send_load(input int id, input logic [7:0] b, input logic [9:0] a);
      rx_data[id]   = b;
      rx_valid[id]  = 1'b1;
      addr_load[id] = 1'b1;
      addr_in[id]   = a;
      @(posedge CLK);
      #1;
      rx_valid[id]  = 1'b0;
      addr_load[id] = 1'b0;
   endtask

   task automatic load(input int id, input logic [9:0] a);
      addr_load[id] = 1'b1;
      addr_in[id]   = a;
      @(posedge CLK);
      #1 addr_load[id] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Bounded wait for every queued write to appear.
   task automatic drain(input string tag);
      int budget = 10;
      while (pending() > 0 && budget > 0) begin
         @(posedge CLK);
         #1;
         budget--;
      end
      check({tag, "_writes_missing"}, 32'(pending()), 32'd0);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      RST_N     = 1'b0;
      rx_valid  = '0;
      addr_load = '0;
      for (int i = 0; i < 4; i++) begin
         rx_data[i] = '0;
         addr_in[i] = '0;
      end

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      check("rst_wr_en",   32'(if_def.WR_EN),   32'd0);
      check("rst_wr_data", 32'(if_def.WR_DATA), 32'd0);
      check("rst_full",    32'(if_stop.FULL),   32'd0);
      check("rst_dropped", 32'(if_def.DROPPED), 32'd0);
      RST_N = 1'b1;
      idle(2);

      // Two words, back to back, second word's first byte lands in the WRITE cycle
      send_byte(0, 8'h12);
      send_last(0, 8'h34, 10'd0, 32'h1234);
      send_byte(0, 8'h56);
      send_last(0, 8'h78, 10'd1, 32'h5678);
      drain("basic");
      idle(3);
      check("hold_wr_data", 32'(if_def.WR_DATA), 32'h5678);
      check("hold_wr_en",   32'(if_def.WR_EN),   32'd0);

      // ADDR_LOAD during WRITE: write keeps the old pointer, next word uses the load
      load(0, 10'd5);
      send_byte(0, 8'hA1);
      send_last(0, 8'hA2, 10'd5, 32'hA1A2);
      load(0, 10'h200);
      send_byte(0, 8'hB1);
      send_last(0, 8'hB2, 10'h200, 32'hB1B2);
      drain("load_in_write");

      // Wrap from the top address back to 0
      load(0, 10'h3FF);
      send_byte(0, 8'hC1);
      send_last(0, 8'hC2, 10'h3FF, 32'hC1C2);
      send_byte(0, 8'hD1);
      send_last(0, 8'hD2, 10'd0, 32'hD1D2);
      drain("wrap");
      check("wrap_no_drop", 32'(if_def.DROPPED), 32'd0);

      // Idle timeout: partial byte discarded after exactly 100 idle clocks
      load(0, 10'd0);
      send_byte(0, 8'hAA);
      idle(99);
      check("timeout_not_yet", 32'(if_def.DROPPED), 32'd0);
      idle(1);
      check("timeout_dropped", 32'(if_def.DROPPED), 32'd1);
      send_byte(0, 8'h01);
      send_last(0, 8'h02, 10'd0, 32'h0102);
      drain("timeout");
      check("timeout_sticky", 32'(if_def.DROPPED), 32'd1);

      // Stop mode: four writes fill the space, fifth word dropped
      for (int w = 0; w < 4; w++) begin
         send_byte(1, 8'(8'h10 + w));
         send_last(1, 8'(8'h20 + w), 10'(w), {16'h0, 8'(8'h10 + w), 8'(8'h20 + w)});
         drain("stop_fill");
         check($sformatf("stop_full_after_%0d", w), 32'(if_stop.FULL), (w == 3) ? 32'd1 : 32'd0);
      end
      check("stop_no_drop_yet", 32'(if_stop.DROPPED), 32'd0);
      send_byte(1, 8'h55);
      send_byte(1, 8'h66);
      idle(2);
      check("stop_drop_flag", 32'(if_stop.DROPPED), 32'd1);
      check("stop_full_held", 32'(if_stop.FULL),    32'd1);
      load(1, 10'd0);
      check("stop_load_clears_full", 32'(if_stop.FULL),    32'd0);
      check("stop_load_keeps_drop",  32'(if_stop.DROPPED), 32'd1);
      send_byte(1, 8'h77);
      send_last(1, 8'h88, 10'd0, 32'h7788);
      drain("stop_reload");

      // 3-byte words, RX_VALID every clock
      send_byte(2, 8'h01);
      send_byte(2, 8'h02);
      send_last(2, 8'h03, 10'd0, 32'h010203);
      send_byte(2, 8'h04);
      send_byte(2, 8'h05);
      send_last(2, 8'h06, 10'd1, 32'h040506);
      drain("b3_stream");

      // ADDR_LOAD with RX_VALID: that byte starts a fresh word at the loaded address
      send_byte(2, 8'h11);
      send_load(2, 8'h22, 10'h010);
      send_byte(2, 8'h33);
      send_last(2, 8'h44, 10'h010, 32'h223344);
      drain("b3_load_with_byte");

      // 1-byte words: every byte written, pointer wraps 7 -> 0
      for (int i = 0; i < 9; i++) begin
         send_last(3, 8'(8'hE0 + i), 10'(i % 8), 32'(8'hE0 + i));
      end
      drain("b1_stream");

      // Reset mid-word: outputs clear immediately, partial byte gone
      send_byte(0, 8'hC3);
      #2 RST_N = 1'b0;
      #1;
      check("midrst_wr_data", 32'(if_def.WR_DATA),  32'd0);
      check("midrst_dropped", 32'(if_def.DROPPED),  32'd0);
      check("midrst_wr_en",   32'(if_def.WR_EN),    32'd0);
      check("midrst_stop_dropped", 32'(if_stop.DROPPED), 32'd0);
      repeat (2) @(posedge CLK);
      #1 RST_N = 1'b1;
      idle(1);
      send_byte(0, 8'hBE);
      send_last(0, 8'hEF, 10'd0, 32'hBEEF);
      drain("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
